ahb_spi_master: RTL

//  AHB-Lite slave on a CM3 TARGEXP port. Serialises 8-bit SPI transfers for the board's SD / W5500 / flash headers.

---
 rtl/ahb_spi_master.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_spi_master
//  Purpose  : AHB-Lite slave that serialises 8-bit SPI transfers (modes 0-3)
//             with programmable SCLK divider, software CS and done interrupt.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_spi_master #(
  parameter logic [7:0] DIV_RST = 8'd3,
  parameter logic       CS_RST  = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        INT_REQ,
  output logic        SPI_SCLK,
  output logic        SPI_CS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO
);

  localparam logic [1:0] c_addr_ctrl = 2'd0;
  localparam logic [1:0] c_addr_div  = 2'd1;
  localparam logic [1:0] c_addr_data = 2'd2;
  localparam logic [1:0] c_addr_stat = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  // Bus data-phase tracking
  logic       r_valid;
  logic       r_write;
  logic [1:0] r_addr;

  // Programmer-visible registers
  logic       r_cpol;
  logic       r_cpha;
  logic       r_cs;
  logic       r_ie;
  logic [7:0] r_div;
  logic [7:0] r_rx;
  logic       r_done;
  logic       r_ovr;

  // Transfer engine
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [3:0] r_edge;
  logic       r_sclk;
  logic       r_mosi;
  logic [7:0] r_tx;
  logic [7:0] r_rxsh;
  logic       r_lcpol;
  logic       r_lcpha;
  logic [7:0] r_ldiv;

  logic w_accept;
  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_div;
  logic w_wr_data;
  logic w_wr_stat;
  logic w_busy;
  logic w_start;
  logic w_ovr_set;
  logic w_tick;
  logic w_edge;
  logic w_finish;
  logic w_sample;
  logic w_unused_ok;

  assign w_accept  = HSEL & HTRANS[1];
  assign w_wr      = r_valid & r_write;
  assign w_wr_ctrl = w_wr & (r_addr == c_addr_ctrl);
  assign w_wr_div  = w_wr & (r_addr == c_addr_div);
  assign w_wr_data = w_wr & (r_addr == c_addr_data);
  assign w_wr_stat = w_wr & (r_addr == c_addr_stat);
  assign w_busy    = (r_state != S_IDLE);
  assign w_start   = w_wr_data & ~w_busy;
  assign w_ovr_set = w_wr_data & w_busy;
  // CPHA=0 samples on even edges, CPHA=1 on odd edges
  assign w_sample  = (r_edge[0] == r_lcpha);

  assign w_unused_ok = ^{HSIZE, HADDR[15:4], HADDR[1:0], HWDATA[31:8]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign INT_REQ   = r_done & r_ie;
  assign SPI_SCLK  = r_sclk;
  assign SPI_CS    = r_cs;
  assign SPI_MOSI  = r_mosi;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= 2'd0;
    end else if (HREADY) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_write <= HWRITE;
        r_addr  <= HADDR[3:2];
      end
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (r_valid && !r_write) begin
      case (r_addr)
        c_addr_ctrl: HRDATA = {28'd0, r_ie, r_cs, r_cpha, r_cpol};
        c_addr_div:  HRDATA = {24'd0, r_div};
        c_addr_data: HRDATA = {24'd0, r_rx};
        default:     HRDATA = {29'd0, r_ovr, r_done, w_busy};
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_cs   <= CS_RST;
      r_ie   <= 1'b0;
      r_div  <= DIV_RST;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_cpol <= HWDATA[0];
        r_cpha <= HWDATA[1];
        r_cs   <= HWDATA[2];
        r_ie   <= HWDATA[3];
      end
      if (w_wr_div) begin
        r_div <= HWDATA[7:0];
      end
      // A completion in the same cycle as a W1C keeps the flag set
      if (w_finish) begin
        r_done <= 1'b1;
      end else if (w_wr_stat && HWDATA[1]) begin
        r_done <= 1'b0;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (w_wr_stat && HWDATA[2]) begin
        r_ovr <= 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick      = (r_cnt == r_ldiv);
    w_edge      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (w_tick) begin
          w_edge = 1'b1;
          if (r_edge == 4'd15) begin
            w_state_nxt = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (w_tick) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_cnt   <= 8'd0;
      r_edge  <= 4'd0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_tx    <= 8'd0;
      r_rxsh  <= 8'd0;
      r_rx    <= 8'd0;
      r_lcpol <= 1'b0;
      r_lcpha <= 1'b0;
      r_ldiv  <= 8'd0;
    end else begin
      if (r_state == S_IDLE || w_tick) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_start) begin
        r_edge  <= 4'd0;
        r_lcpol <= r_cpol;
        r_lcpha <= r_cpha;
        r_ldiv  <= r_div;
        r_tx    <= HWDATA[7:0];
        r_mosi  <= HWDATA[7];
        r_sclk  <= r_cpol;
      end else if (w_edge) begin
        r_edge <= r_edge + 4'd1;
        r_sclk <= ~r_sclk;
        if (w_sample) begin
          r_rxsh <= {r_rxsh[6:0], SPI_MISO};
        end else if (r_lcpha) begin
          r_mosi <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end else begin
          // CPHA=0 already presented TX[7] at start, so the next bit is [6]
          r_mosi <= r_tx[6];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end else if (r_state == S_IDLE) begin
        r_sclk <= r_cpol;
      end

      if (w_finish) begin
        r_rx <= r_rxsh;
      end
    end
  end

endmodule
`default_nettype wire
